cnn_conv_acc: RTL
=================

# cnn_conv_acc

Accumulation stage directly downstream of the signed 13×8 weight multiplier in the convolution datapath. Consumes one signed 22-bit product per handshake. Sums a fixed-length kernel window of KLEN products onto a per-window bias, then rescales the result to the 13-bit activation format. Saturates and optionally applies ReLU before presenting the activation to the next layer stage.

## Interface
- PROD_WIDTH, 22, width of signed product input (multiplier output)
- OUT_WIDTH, 13, width of signed activation output (13-bit, 7 fractional bits)
- ACC_WIDTH, 28, signed accumulator width; must be ≥ PROD_WIDTH + clog2(KLEN) + 1
- KLEN, 25, products per window (5×5 kernel); must be ≥ 1
- SHIFT, 7, right-shift aligning accumulator to output fraction; bias is pre-shifted left by SHIFT
- RELU, 1, 1 = clamp negative results to 0, 0 = pass signed result
- ap_clk  in  1  single clock, all state on rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  product/bias valid
- in_ready  out  1  stage accepts a product this cycle
- in_data  in  PROD_WIDTH  signed product
- in_bias  in  OUT_WIDTH  signed bias; sampled only with the first product of a window
- out_valid  out  1  activation valid
- out_ready  in  1  downstream accepts activation
- out_data  out  OUT_WIDTH  signed activation

## Operation
- States: ACC (collecting products) and HOLD (result pending).
- Counter cnt tracks the index within the window, 0..KLEN-1.
- A product is accepted when in_valid && in_ready.
- In ACC, in_ready = 1.
- Accept with cnt == 0: acc ← sext(in_bias) <<< SHIFT + sext(in_data).
- Accept with cnt > 0: acc ← acc + sext(in_data).
- On accept, cnt increments.
- Accept with cnt == KLEN-1:
  - the final sum (acc + in_data, or the bias form when KLEN = 1) goes through the output path;
  - out_data is registered from it, out_valid ← 1, cnt ← 0, state ← HOLD.
- Output path:
  - r = final_sum >>> SHIFT (arithmetic shift, floor, no rounding);
  - saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], i.e. [-4096, 4095];
  - if RELU = 1 and the result < 0, output 0.
- In HOLD: in_ready = 0, out_data and out_valid held stable. When out_ready = 1: out_valid ← 0, state ← ACC.
- in_valid while in_ready = 0 is ignored and is the upstream's responsibility to hold.
- in_data and in_bias are don't-care when not accepted.
- The accumulator never overflows given the ACC_WIDTH constraint; no wrap handling is required.

## Timing
- Reset (ap_rst_n low, asynchronous):
  - state = ACC, cnt = 0, acc = 0;
  - in_ready = 0, out_valid = 0, out_data = 0.
- in_ready is registered: it rises on the first ap_clk edge after ap_rst_n deasserts.
- Latency: out_valid asserts on the edge that accepts the KLEN-th product, visible the following cycle.
- in_ready falls in that same cycle.
- Pop: out_valid and in_ready change on the edge where out_valid && out_ready.
  - Next window's first product is accepted no earlier than the cycle after the pop.
  - Throughput is one activation per KLEN+1 cycles at full rate.
- A gap cycle (in_valid = 0) during ACC leaves acc and cnt unchanged.
- Reset mid-window discards the partial sum; the next accepted product is treated as cnt == 0 and its bias is sampled.
- Reset during HOLD drops the pending result.
- KLEN = 1: every accepted product produces an output.

## Test plan
- Basic sum (KLEN=25, SHIFT=7, RELU=1): bias 0, 25 products of 128 → sum 3200, out_data = 25, out_valid one cycle after the 25th accept.
- Bias: bias 64 with the first product, then 25×128 → (8192+3200)>>>7, out_data = 89.
- Saturation and ReLU:
  - 25 products of 1048575 → out_data = 4095 (clamped);
  - 25 products of -128 with RELU=1 → out_data = 0;
  - 25 products of -128 with RELU=0 → out_data = -25.
- Floor (RELU=0): bias 0, one product -1 then 24 zeros → out_data = -1; one product 127 then zeros → 0.
- Backpressure and gaps:
  - random in_valid gaps give the same result as the gap-free case;
  - out_ready low for 10 cycles → out_data stable, in_ready = 0, no product absorbed;
  - pop → in_ready = 1 next cycle.
- Reset: assert ap_rst_n low after 10 products → all outputs at reset values. After release, a fresh window of 25×128 with bias 0 yields 25, with no residue from the aborted window.

Source files
------------

// File: rtl/cnn_conv_acc.sv
// rtl/cnn_conv_acc.sv - kernel-window accumulator with bias, rescale, saturation and optional ReLU
// Sums KLEN signed products onto a pre-shifted bias and emits one 13-bit activation per window.
module cnn_conv_acc #(
  parameter int PROD_WIDTH = 22,
  parameter int OUT_WIDTH  = 13,
  parameter int ACC_WIDTH  = 28,
  parameter int KLEN       = 25,
  parameter int SHIFT      = 7,
  parameter int RELU       = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  input  logic signed [OUT_WIDTH-1:0]  in_bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data
);

  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KLEN - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {ACC, HOLD} state_t;

  state_t state, state_n;
  logic   ready_n;

  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] data_ext;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [OUT_WIDTH-1:0] act;
  logic                        accept;
  logic                        last;

  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CNT_LAST);
  assign bias_ext = ACC_WIDTH'(in_bias);
  assign data_ext = ACC_WIDTH'(in_data);

  // The first product of a window restarts from the bias instead of the running sum.
  assign base    = (cnt == '0) ? (bias_ext <<< SHIFT) : acc;
  assign sum     = base + data_ext;
  assign shifted = sum >>> SHIFT;

  always_comb begin
    act = shifted[OUT_WIDTH-1:0];
    if (shifted > OUT_MAX) begin
      act = OUT_MAX[OUT_WIDTH-1:0];
    end else if (shifted < OUT_MIN) begin
      act = OUT_MIN[OUT_WIDTH-1:0];
    end
    if ((RELU != 0) && act[OUT_WIDTH-1]) begin
      act = '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= ACC;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ACC:     if (accept && last) state_n = HOLD;
      HOLD:    if (out_ready)      state_n = ACC;
      default: state_n = ACC;
    endcase
    // in_ready is registered, so it follows the state we are about to enter.
    ready_n = (state_n == ACC);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        acc <= sum;
        if (last) begin
          cnt       <= '0;
          out_data  <= act;
          out_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
